// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the RISC-V calculator ALU blocks: divider opcodes,
// divider FSM state encoding and small opcode-decode helpers.
package riscv_alu_pkg;

    localparam logic [1:0] DIVOP_DIV  = 2'b00;
    localparam logic [1:0] DIVOP_DIVU = 2'b01;
    localparam logic [1:0] DIVOP_REM  = 2'b10;
    localparam logic [1:0] DIVOP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    // DIV and REM treat operands as two's complement; DIVU/REMU do not.
    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == DIVOP_DIV) || (op == DIVOP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == DIVOP_REM) || (op == DIVOP_REMU);
    endfunction

endpackage

// File: rtl/riscv_div32_div_step.sv
// One bit of restoring division: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             q_in,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] diff_s;

    // The extra top bit of diff_s is the borrow of the trial subtraction.
    always_comb begin
        shifted_s = {rem_in, q_in};
        diff_s    = shifted_s - {2'b00, divisor};
        if (diff_s[WIDTH+1] == 1'b0) begin
            rem_out = diff_s[WIDTH:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted_s[WIDTH:0];
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_div32.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU) with valid/ready handshakes.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
import riscv_alu_pkg::*;

module riscv_div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [1:0]       divcontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG    = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_r, state_s;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r, dvsr_r, dividend_r, result_r;
    logic [CW-1:0]    count_r;
    logic [1:0]       op_r;
    logic             neg_q_r, neg_r_r, zero_r, special_r, div_zero_r;

    logic             accept_s, signed_s, a_neg_s, b_neg_s, zero_s, ovf_s, special_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, special_res_s;
    logic [WIDTH:0]   step_rem_s;
    logic             step_q_s;
    logic [WIDTH-1:0] q_final_s, r_final_s, calc_res_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .divisor (dvsr_r),
        .q_in    (quo_r[WIDTH-1]),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Request decode: operand magnitudes, signs and the two special cases.
    always_comb begin
        accept_s  = in_valid && (state_r == S_IDLE);
        signed_s  = is_signed_op(divcontrol);
        a_neg_s   = signed_s && srca[WIDTH-1];
        b_neg_s   = signed_s && srcb[WIDTH-1];
        a_mag_s   = a_neg_s ? (~srca + {{(WIDTH-1){1'b0}}, 1'b1}) : srca;
        b_mag_s   = b_neg_s ? (~srcb + {{(WIDTH-1){1'b0}}, 1'b1}) : srcb;
        zero_s    = (srcb == {WIDTH{1'b0}});
        ovf_s     = signed_s && (srca == MIN_NEG) && (srcb == {WIDTH{1'b1}});
        special_s = zero_s || ovf_s;
        // Overflow quotient equals the dividend itself; divide-by-zero quotient is all ones.
        if (is_rem_op(divcontrol)) begin
            special_res_s = zero_s ? srca : {WIDTH{1'b0}};
        end else begin
            special_res_s = zero_s ? {WIDTH{1'b1}} : srca;
        end
    end

    // Final step result with sign correction applied.
    always_comb begin
        q_final_s = {quo_r[WIDTH-2:0], step_q_s};
        r_final_s = step_rem_s[WIDTH-1:0];
        if (neg_q_r) begin
            q_final_s = ~q_final_s + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            q_final_s = q_final_s;
        end
        if (neg_r_r) begin
            r_final_s = ~r_final_s + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_final_s = r_final_s;
        end
        calc_res_s = is_rem_op(op_r) ? r_final_s : q_final_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
`ifdef DIV_EARLY_OUT_EN
                    state_s = special_s ? S_DONE : S_CALC;
`else
                    state_s = S_CALC;
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (count_r == LAST_COUNT) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latching, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_r      <= {(WIDTH+1){1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            dvsr_r     <= {WIDTH{1'b0}};
            dividend_r <= {WIDTH{1'b0}};
            count_r    <= {CW{1'b0}};
            op_r       <= 2'b00;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            zero_r     <= 1'b0;
            special_r  <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            div_zero_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        rem_r      <= {(WIDTH+1){1'b0}};
                        quo_r      <= a_mag_s;
                        dvsr_r     <= b_mag_s;
                        dividend_r <= special_res_s;
                        count_r    <= {CW{1'b0}};
                        op_r       <= divcontrol;
                        neg_q_r    <= a_neg_s ^ b_neg_s;
                        neg_r_r    <= a_neg_s;
                        zero_r     <= zero_s;
                        special_r  <= special_s;
`ifdef DIV_EARLY_OUT_EN
                        if (special_s) begin
                            result_r   <= special_res_s;
                            div_zero_r <= zero_s;
                        end
`endif
                    end
                end
                S_CALC: begin
                    rem_r   <= step_rem_s;
                    quo_r   <= {quo_r[WIDTH-2:0], step_q_s};
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (count_r == LAST_COUNT) begin
                        result_r   <= special_r ? dividend_r : calc_res_s;
                        div_zero_r <= zero_r;
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign result    = result_r;
    assign div_zero  = div_zero_r;

endmodule
